// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, sync-read imem and 2-entry skid buffer to decode.
// Optional perf counters (fetch_count/stall_count) when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          redirect_valid,
  input  logic [63:0]                   redirect_pc,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   instruction,
  output logic [63:0]                   pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] mem_q [IMEM_DEPTH];

  logic [63:0] fetch_pc_q;
  logic [63:0] fetch_pc_d;
  logic        run_q;

  logic        rd_vld_q;
  logic [63:0] rd_pc_q;
  logic [31:0] rd_data_q;

  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [31:0] b0_w_q;
  logic [31:0] b1_w_q;
  logic [63:0] b0_pc_q;
  logic [63:0] b1_pc_q;
  logic [31:0] b0_w_d;
  logic [31:0] b1_w_d;
  logic [63:0] b0_pc_d;
  logic [63:0] b1_pc_d;

  logic [31:0] last_w_q;
  logic [63:0] last_pc_q;

  logic [31:0] s0_w;
  logic [31:0] s1_w;
  logic [63:0] s0_pc;
  logic [63:0] s1_pc;

  logic [31:0] head_w;
  logic [63:0] head_pc;

  logic [1:0]  occ;
  logic [1:0]  occ_pop;
  logic        pop;
  logic        issue;

  logic        unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // Head of the queue: buffered word first, else the word returning from memory.
  always_comb begin
    head_w  = last_w_q;
    head_pc = last_pc_q;
    if (cnt_q != 2'd0) begin
      head_w  = b0_w_q;
      head_pc = b0_pc_q;
    end else if (rd_vld_q) begin
      head_w  = rd_data_q;
      head_pc = rd_pc_q;
    end
  end

  assign out_valid   = (cnt_q != 2'd0) | rd_vld_q;
  assign instruction = head_w;
  assign pc_out      = head_pc;

  assign pop     = out_valid & out_ready;
  assign occ     = cnt_q + {1'b0, rd_vld_q};
  assign occ_pop = occ - {1'b0, pop};
  assign issue   = run_q & ~load_en & ~redirect_valid & (occ_pop < 2'd2);

  // Ordered view of live words: buffer entries then the returning read.
  always_comb begin
    s0_w  = rd_data_q;
    s0_pc = rd_pc_q;
    s1_w  = rd_data_q;
    s1_pc = rd_pc_q;
    if (cnt_q != 2'd0) begin
      s0_w  = b0_w_q;
      s0_pc = b0_pc_q;
    end
    if (cnt_q == 2'd2) begin
      s1_w  = b1_w_q;
      s1_pc = b1_pc_q;
    end
  end

  // Buffer next state: drop the head on a transfer, flush on redirect.
  always_comb begin
    b0_w_d  = pop ? s1_w  : s0_w;
    b0_pc_d = pop ? s1_pc : s0_pc;
    b1_w_d  = pop ? rd_data_q : s1_w;
    b1_pc_d = pop ? rd_pc_q   : s1_pc;
    cnt_d   = redirect_valid ? 2'd0 : occ_pop;
  end

  // Fetch PC: redirect target (word aligned), else advance on issue.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  // Program load port and synchronous read port of the instruction memory.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
    if (issue) begin
      rd_data_q <= mem_q[fetch_pc_q[2 +: AW]];
    end
  end

  // Fetch control, in-flight tracking, skid buffer and last-delivered word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      run_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_pc_q    <= 64'h0;
      cnt_q      <= 2'd0;
      b0_w_q     <= 32'h0;
      b1_w_q     <= 32'h0;
      b0_pc_q    <= 64'h0;
      b1_pc_q    <= 64'h0;
      last_w_q   <= 32'h0;
      last_pc_q  <= 64'h0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      run_q      <= 1'b1;
      rd_vld_q   <= issue;
      if (issue) begin
        rd_pc_q <= fetch_pc_q;
      end
      cnt_q   <= cnt_d;
      b0_w_q  <= b0_w_d;
      b1_w_q  <= b1_w_d;
      b0_pc_q <= b0_pc_d;
      b1_pc_q <= b1_pc_d;
      if (pop) begin
        last_w_q  <= head_w;
        last_pc_q <= head_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Transfer and stall counters; free-running, only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (out_valid & ~out_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector tables, corner sequences and random traffic
// against a queue-based model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   instruction;
  logic [63:0]   pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetch_count;
  logic [31:0]   stall_count;
`endif

  instr_fetch_unit #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (64'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .instruction   (instruction),
    .pc_out        (pc_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [63:0] rpc;
    logic        ev;
    logic [63:0] epc;
    logic [31:0] ew;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] wfix [8];
  logic [31:0] mem_m [DEPTH];
  logic [63:0] q_pc [$];
  logic [31:0] q_w [$];
  logic [63:0] m_pc;
  logic [63:0] last_pc;
  logic [31:0] last_w;
  bit          m_run;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_w.delete();
    m_pc    = 64'h0;
    last_pc = 64'h0;
    last_w  = 32'h0;
    m_run   = 1'b0;
    m_fetch = 32'h0;
    m_stall = 32'h0;
  endtask

  task automatic mcheck();
    bit v;
    v = (q_pc.size() != 0);
    chk("m_valid", 64'(out_valid), 64'(v));
    chk("m_pc", pc_out, v ? q_pc[0] : last_pc);
    chk("m_instr", 64'(instruction), 64'(v ? q_w[0] : last_w));
`ifdef FETCH_PERF_CNT_EN
    chk("m_fetch_cnt", 64'(fetch_count), 64'(m_fetch));
    chk("m_stall_cnt", 64'(stall_count), 64'(m_stall));
`endif
  endtask

  // One cycle of the fetch stream: deliver, then redirect or fetch ahead.
  task automatic model_step(input bit rdy, input bit redir,
                            input logic [63:0] rpc, input bit le,
                            input logic [AW-1:0] la, input logic [31:0] ld);
    bit v;
    v = (q_pc.size() != 0);
    if (v && !rdy) m_stall++;
    if (v && rdy) begin
      last_pc = q_pc.pop_front();
      last_w  = q_w.pop_front();
      m_fetch++;
    end
    if (redir) begin
      q_pc.delete();
      q_w.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else if (m_run && !le && q_pc.size() < 2) begin
      q_pc.push_back(m_pc);
      q_w.push_back(mem_m[m_pc[2 +: AW]]);
      m_pc = m_pc + 64'd4;
    end
    if (le) mem_m[la] = ld;
    m_run = 1'b1;
  endtask

  task automatic apply(input bit rdy, input bit redir, input logic [63:0] rpc,
                       input bit le, input logic [AW-1:0] la,
                       input logic [31:0] ld);
    mcheck();
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    load_en        = le;
    load_addr      = la;
    load_data      = ld;
    model_step(rdy, redir, rpc, le, la, ld);
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 1'b0, 64'h0, 1'b0, '0, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'(v.ev));
    chk({nm, "_pc"}, pc_out, v.epc);
    chk({nm, "_instr"}, 64'(instruction), 64'(v.ew));
    apply(v.rdy, v.redir, v.rpc, 1'b0, '0, 32'h0);
  endtask

  vec_t va [6];
  vec_t vb [16];

  initial begin
    logic [63:0] rpc;
    wfix[0] = 32'h00500093; wfix[1] = 32'h00A00113;
    wfix[2] = 32'h002081B3; wfix[3] = 32'h00000013;
    wfix[4] = 32'h00108093; wfix[5] = 32'h00210113;
    wfix[6] = 32'h003181B3; wfix[7] = 32'h0041A213;

    va[0] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0,  32'h0};
    va[1] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h0,  wfix[0]};
    va[2] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h4,  wfix[1]};
    va[3] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h8,  wfix[2]};
    va[4] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'hC,  wfix[3]};
    va[5] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h10, wfix[4]};

    vb[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  32'h0};
    vb[1]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0,  wfix[0]};
    for (int i = 2; i <= 6; i++)
      vb[i] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h4, wfix[1]};
    vb[7]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h4,  wfix[1]};
    vb[8]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h8,  wfix[2]};
    vb[9]  = '{1'b1, 1'b0, 64'h0,  1'b1, 64'hC,  wfix[3]};
    vb[10] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h10, wfix[4]};
    vb[11] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h10, wfix[4]};
    vb[12] = '{1'b0, 1'b1, 64'hE,  1'b1, 64'h10, wfix[4]};
    vb[13] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'hC,  wfix[3]};
    vb[14] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'hC,  wfix[3]};
    vb[15] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h10, wfix[4]};

    reset          = 1'b0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    model_reset();

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = (i < 8) ? wfix[i] : $urandom;
      mem_m[i]  = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_instr", 64'(instruction), 64'h0);
    chk("rst_pc", pc_out, 64'h0);

    release_rst();
    for (int i = 0; i < 6; i++) run_vec(va[i], "s1");

    @(posedge clk);
    #2;
    chk("s5_pre_valid", 64'(out_valid), 64'h1);
    reset = 1'b0;
    #1;
    chk("s5_async_valid", 64'(out_valid), 64'h0);
    chk("s5_async_instr", 64'(instruction), 64'h0);
    chk("s5_async_pc", pc_out, 64'h0);
    model_reset();
    repeat (2) @(negedge clk);

    release_rst();
    for (int i = 0; i < 16; i++) begin
`ifdef FETCH_PERF_CNT_EN
      if (i == 10) begin
        @(posedge clk);
        #1;
        chk("s6_fetch_count", 64'(fetch_count), 64'd4);
        chk("s6_stall_count", 64'(stall_count), 64'd5);
      end
`endif
      run_vec(vb[i], "s23");
    end

    @(negedge clk);
    apply(1'b1, 1'b1, 64'hFC, 1'b0, '0, 32'h0);
    @(negedge clk);
    chk("s4_gap_valid", 64'(out_valid), 64'h0);
    apply(1'b1, 1'b0, 64'h0, 1'b0, '0, 32'h0);
    @(negedge clk);
    chk("s4_pc_fc", pc_out, 64'hFC);
    chk("s4_word63", 64'(instruction), 64'(mem_m[63]));
    apply(1'b1, 1'b0, 64'h0, 1'b0, '0, 32'h0);
    @(negedge clk);
    chk("s4_pc_100", pc_out, 64'h100);
    chk("s4_wrap_word0", 64'(instruction), 64'(wfix[0]));
    apply(1'b1, 1'b0, 64'h0, 1'b0, '0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      bit rd;
      bit le;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      le  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 64'($urandom_range(0, 255));
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: rpc = {$urandom, $urandom};
      endcase
      @(negedge clk);
      apply(rdy, rd, rpc, le, AW'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    @(negedge clk);
    mcheck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
